simeck_dec: RTL

Iterative Simeck32/64 decryption core: the receive-side counterpart of the `simeck` encryption block. It accepts a 32-bit ciphertext and 64-bit key on a start pulse and expands the key schedule forward. It then runs 32 inverse rounds, one per clock, walking the key schedule backward. It returns the 32-bit plaintext with a one-cycle done pulse.

---
 rtl/simeck_dec.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/simeck_dec.sv
// Iterative Simeck32/64 decryption: forward key expansion, then one inverse round per clock.
// Optional key cache enabled by defining SIMECK_DEC_KEYCACHE_EN.
module simeck_dec #(
  parameter int unsigned ROUNDS = 32,
  parameter int unsigned WORD   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2*WORD-1:0] inp,
  input  logic [4*WORD-1:0] key,
  output logic [2*WORD-1:0] out,
  output logic              busy,
  output logic              done
);

  localparam int unsigned     CntW     = $clog2(ROUNDS);
  localparam logic [CntW-1:0] LastExp  = CntW'(ROUNDS - 2);
  localparam logic [CntW-1:0] LastRnd  = CntW'(ROUNDS - 1);
  localparam logic [WORD-1:0] KeyConst = {{(WORD-2){1'b1}}, 2'b00};
  localparam logic [4:0]      LfsrSeed = 5'b11111;

  typedef enum logic [1:0] {StIdle, StExpand, StDecrypt, StDone} state_e;

  state_e            state_q, state_d;
  logic [WORD-1:0]   l_q, l_d, r_q, r_d;
  logic [4*WORD-1:0] ks_q, ks_d;
  logic [4:0]        lfsr_q, lfsr_d;
  logic [ROUNDS-1:0] zh_q, zh_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2*WORD-1:0] out_q, out_d;
  logic              busy_q, busy_d, done_q, done_d;

  logic [WORD-1:0]   w0, w1, w2, w3, r_new;
  logic              z_exp, z_dec;
  logic [4*WORD-1:0] ks_fwd, ks_inv;
  logic [ROUNDS-1:0] zh_shift;

`ifdef SIMECK_DEC_KEYCACHE_EN
  logic              cv_q, cv_d, hit;
  logic [4*WORD-1:0] ck_q, ck_d, cks_q, cks_d;
  logic [ROUNDS-1:0] czh_q, czh_d;
`endif

  function automatic logic [WORD-1:0] rnd_f(input logic [WORD-1:0] x);
    return (x & {x[WORD-6:0], x[WORD-1:WORD-5]}) ^ {x[WORD-2:0], x[WORD-1]};
  endfunction

  assign {w3, w2, w1, w0} = ks_q;
  assign z_exp    = lfsr_q[0];
  // z_j lands in bit j+1 after expansion, so round i reads z_{i-1} at index i.
  assign z_dec    = zh_q[cnt_q];
  assign zh_shift = {z_exp, zh_q[ROUNDS-1:1]};
  assign ks_fwd   = {w0 ^ rnd_f(w1) ^ KeyConst ^ WORD'(z_exp), w3, w2, w1};
  assign ks_inv   = {w2, w1, w0, w3 ^ rnd_f(w0) ^ KeyConst ^ WORD'(z_dec)};
  assign r_new    = l_q ^ rnd_f(r_q) ^ w0;

`ifdef SIMECK_DEC_KEYCACHE_EN
  assign hit = cv_q && (key == ck_q);
`endif

  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    r_d     = r_q;
    ks_d    = ks_q;
    lfsr_d  = lfsr_q;
    zh_d    = zh_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SIMECK_DEC_KEYCACHE_EN
    cv_d    = cv_q;
    ck_d    = ck_q;
    cks_d   = cks_q;
    czh_d   = czh_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          {l_d, r_d} = inp;
          busy_d     = 1'b1;
          lfsr_d     = LfsrSeed;
`ifdef SIMECK_DEC_KEYCACHE_EN
          if (hit) begin
            ks_d    = cks_q;
            zh_d    = czh_q;
            cnt_d   = LastRnd;
            state_d = StDecrypt;
          end else begin
            // Invalidate until this key's schedule has been fully expanded.
            cv_d    = 1'b0;
            ck_d    = key;
            ks_d    = key;
            zh_d    = '0;
            cnt_d   = '0;
            state_d = StExpand;
          end
`else
          ks_d    = key;
          zh_d    = '0;
          cnt_d   = '0;
          state_d = StExpand;
`endif
        end
      end
      StExpand: begin
        ks_d   = ks_fwd;
        lfsr_d = {lfsr_q[2] ^ lfsr_q[0], lfsr_q[4:1]};
        zh_d   = zh_shift;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LastExp) begin
          cnt_d   = LastRnd;
          state_d = StDecrypt;
`ifdef SIMECK_DEC_KEYCACHE_EN
          cv_d  = 1'b1;
          cks_d = ks_fwd;
          czh_d = zh_shift;
`endif
        end
      end
      StDecrypt: begin
        l_d = r_q;
        r_d = r_new;
        if (cnt_q != '0) begin
          ks_d  = ks_inv;
          cnt_d = cnt_q - 1'b1;
        end else begin
          out_d   = {r_q, r_new};
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      l_q     <= '0;
      r_q     <= '0;
      ks_q    <= '0;
      lfsr_q  <= '0;
      zh_q    <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SIMECK_DEC_KEYCACHE_EN
      cv_q    <= 1'b0;
      ck_q    <= '0;
      cks_q   <= '0;
      czh_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      r_q     <= r_d;
      ks_q    <= ks_d;
      lfsr_q  <= lfsr_d;
      zh_q    <= zh_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SIMECK_DEC_KEYCACHE_EN
      cv_q    <= cv_d;
      ck_q    <= ck_d;
      cks_q   <= cks_d;
      czh_q   <= czh_d;
`endif
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
